// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
package fifo_pkg;

    localparam int FIFO_MIN_DEPTH     = 4;
    localparam int FIFO_DEF_WIDTH     = 8;
    localparam int FIFO_DEF_DEPTH     = 16;
    localparam int FIFO_DEF_AE_LEVEL  = 2;
    localparam int FIFO_DEF_AF_MARGIN = 2;

    // Pointer width: address bits plus one wrap bit.
    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit fifo_is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Data/handshake/status bundle between a FIFO and its user.
interface sync_fifo_param_if #(
    parameter int WIDTH = fifo_pkg::FIFO_DEF_WIDTH,
    parameter int DEPTH = fifo_pkg::FIFO_DEF_DEPTH
);
    import fifo_pkg::*;

    localparam int CW = fifo_ptr_w(DEPTH);

    logic             flush_i;
    logic             wr_en_i;
    logic [WIDTH-1:0] wdata_i;
    logic             rd_en_i;
    logic [WIDTH-1:0] rdata_o;
    logic             full_o;
    logic             empty_o;
    logic             almost_full_o;
    logic             almost_empty_o;
    logic [CW-1:0]    count_o;
    logic             wr_error_o;
    logic             rd_error_o;

    modport slave (
        input  flush_i, wr_en_i, wdata_i, rd_en_i,
        output rdata_o, full_o, empty_o, almost_full_o, almost_empty_o,
               count_o, wr_error_o, rd_error_o
    );

    modport master (
        output flush_i, wr_en_i, wdata_i, rd_en_i,
        input  rdata_o, full_o, empty_o, almost_full_o, almost_empty_o,
               count_o, wr_error_o, rd_error_o
    );

endinterface

// File: rtl/fifo_mem_2p.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem_2p #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised synchronous FIFO with wrap-bit pointers, registered occupancy,
// error pulses and optional first-word-fall-through read.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = FIFO_DEF_WIDTH,
    parameter int DEPTH    = FIFO_DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - FIFO_DEF_AF_MARGIN,
    parameter int AE_LEVEL = FIFO_DEF_AE_LEVEL,
    parameter int FWFT     = 0
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    sync_fifo_param_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = fifo_ptr_w(DEPTH);
    localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);

    if (WIDTH < 1) begin : g_err_width
        $error("sync_fifo_param: WIDTH must be >= 1");
    end
    if (!fifo_is_pow2(DEPTH) || (DEPTH < FIFO_MIN_DEPTH)) begin : g_err_depth
        $error("sync_fifo_param: DEPTH must be a power of two and >= 4");
    end
    if (AF_LEVEL > DEPTH) begin : g_err_af
        $error("sync_fifo_param: AF_LEVEL exceeds DEPTH");
    end
    if (AE_LEVEL >= AF_LEVEL) begin : g_err_ae
        $error("sync_fifo_param: AE_LEVEL must be below AF_LEVEL");
    end

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_count;
    logic [WIDTH-1:0] r_rdata;
    logic             r_wr_err;
    logic             r_rd_err;
    logic [WIDTH-1:0] w_mem_rdata;
    logic             w_full;
    logic             w_empty;
    logic             w_wr_acc;
    logic             w_rd_acc;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    // A write into a full FIFO is refused even if a pop frees a slot this cycle.
    assign w_wr_acc = bus.wr_en_i & ~w_full  & ~bus.flush_i;
    assign w_rd_acc = bus.rd_en_i & ~w_empty & ~bus.flush_i;

    fifo_mem_2p #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clk   (clk_i),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (bus.wdata_i),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_wr_err <= 1'b0;
            r_rd_err <= 1'b0;
        end else if (bus.flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_wr_err <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + PW'(1);
                2'b01:   r_count <= r_count - PW'(1);
                default: r_count <= r_count;
            endcase
            r_wr_err <= bus.wr_en_i & w_full;
            r_rd_err <= bus.rd_en_i & w_empty;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rdata <= '0;
        end else if ((FWFT == 0) && w_rd_acc) begin
            r_rdata <= w_mem_rdata;
        end
    end

    // In FWFT mode the head is shown directly; forced to zero while empty so
    // reset and idle present a defined value instead of stale storage.
    assign bus.rdata_o        = (FWFT != 0) ? (w_empty ? '0 : w_mem_rdata) : r_rdata;
    assign bus.full_o         = w_full;
    assign bus.empty_o        = w_empty;
    assign bus.count_o        = r_count;
    assign bus.almost_full_o  = (r_count >= AF_L);
    assign bus.almost_empty_o = (r_count <= AE_L);
    assign bus.wr_error_o     = r_wr_err;
    assign bus.rd_error_o     = r_rd_err;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: standard-read instance plus an FWFT instance.
module tb_sync_fifo_param;

    localparam int W = 8;
    localparam int D = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.WIDTH(W), .DEPTH(D)) bus_s ();
    sync_fifo_param_if #(.WIDTH(W), .DEPTH(D)) bus_f ();

    sync_fifo_param #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_dut_std (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus_s)
    );

    sync_fifo_param #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_dut_fwft (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus_f)
    );

    int         n_checks = 0;
    int         n_fails  = 0;
    int         m_count  = 0;
    logic [7:0] sb[$];
    logic [7:0] sb_f[$];
    logic [7:0] m_rdata  = 8'h00;
    bit         m_werr   = 1'b0;
    bit         m_rerr   = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_std(input string where);
        check_val({where, " count"}, 32'(bus_s.count_o), m_count);
        check_val({where, " full"},  32'(bus_s.full_o), 32'(m_count == D));
        check_val({where, " empty"}, 32'(bus_s.empty_o), 32'(m_count == 0));
        check_val({where, " afull"}, 32'(bus_s.almost_full_o), 32'(m_count >= D - 2));
        check_val({where, " aempty"}, 32'(bus_s.almost_empty_o), 32'(m_count <= 2));
        check_val({where, " wr_err"}, 32'(bus_s.wr_error_o), 32'(m_werr));
        check_val({where, " rd_err"}, 32'(bus_s.rd_error_o), 32'(m_rerr));
        check_val({where, " rdata"}, 32'(bus_s.rdata_o), 32'(m_rdata));
    endtask

    // One clock on the standard instance; the model decides acceptance from its own state.
    task automatic step(input bit fl, input bit wr, input logic [7:0] wd, input bit rd, input string where);
        bit wr_ok;
        bit rd_ok;
        bus_s.flush_i = fl;
        bus_s.wr_en_i = wr;
        bus_s.wdata_i = wd;
        bus_s.rd_en_i = rd;
        wr_ok = !fl && wr && (m_count < D);
        rd_ok = !fl && rd && (m_count > 0);
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
            m_count = 0;
            m_werr  = 1'b0;
            m_rerr  = 1'b0;
        end else begin
            m_werr = wr && !wr_ok;
            m_rerr = rd && !rd_ok;
            if (rd_ok) begin
                m_rdata = sb.pop_front();
                m_count--;
            end
            if (wr_ok) begin
                sb.push_back(wd);
                m_count++;
            end
        end
        bus_s.flush_i = 1'b0;
        bus_s.wr_en_i = 1'b0;
        bus_s.rd_en_i = 1'b0;
        check_std(where);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_s.flush_i = 1'b0;
        bus_s.wr_en_i = 1'b0;
        bus_s.wdata_i = '0;
        bus_s.rd_en_i = 1'b0;
        bus_f.flush_i = 1'b0;
        bus_f.wr_en_i = 1'b0;
        bus_f.wdata_i = '0;
        bus_f.rd_en_i = 1'b0;

        #1 rst_n = 1'b0;
        #2;
        check_std("in_rst");
        check_val("fwft in_rst empty", 32'(bus_f.empty_o), 1);
        check_val("fwft in_rst rdata", 32'(bus_f.rdata_o), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_std("post_rst");

        for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, 8'(i), 1'b0, "fill");
        step(1'b0, 1'b1, 8'hAA, 1'b0, "overflow");
        step(1'b0, 1'b0, 8'h00, 1'b0, "overflow_clr");
        step(1'b0, 1'b1, 8'hBB, 1'b1, "full_wr_rd");
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 8'h00, 1'b1, "drain");
        step(1'b0, 1'b0, 8'h00, 1'b1, "underflow");
        step(1'b0, 1'b0, 8'h00, 1'b0, "underflow_clr");
        step(1'b0, 1'b1, 8'h77, 1'b1, "empty_wr_rd");
        step(1'b0, 1'b0, 8'h00, 1'b1, "pop_77");

        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(8'h20 + i), 1'b0, "pre_wrap");
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b1, "wrap");
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00, 1'b1, "post_wrap");

        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 1'b0, "pre_rst");
        #3 rst_n = 1'b0;
        #1;
        sb.delete();
        m_count = 0;
        m_rdata = 8'h00;
        m_werr  = 1'b0;
        m_rerr  = 1'b0;
        check_std("async_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h50 + i), 1'b0, "pre_flush");
        step(1'b1, 1'b1, 8'hCC, 1'b1, "flush");
        step(1'b0, 1'b1, 8'h11, 1'b0, "post_flush_wr");
        step(1'b0, 1'b0, 8'h00, 1'b1, "post_flush_rd");

        bus_f.wr_en_i = 1'b1;
        bus_f.wdata_i = 8'h5A;
        #1;
        check_val("fwft same_cycle empty", 32'(bus_f.empty_o), 1);
        @(posedge clk); #1;
        bus_f.wr_en_i = 1'b0;
        sb_f.push_back(8'h5A);
        check_val("fwft 5A empty", 32'(bus_f.empty_o), 0);
        check_val("fwft 5A rdata", 32'(bus_f.rdata_o), 32'(sb_f[0]));
        bus_f.wr_en_i = 1'b1;
        bus_f.wdata_i = 8'h33;
        @(posedge clk); #1;
        bus_f.wr_en_i = 1'b0;
        sb_f.push_back(8'h33);
        check_val("fwft hold rdata", 32'(bus_f.rdata_o), 32'(sb_f[0]));
        check_val("fwft count 2", 32'(bus_f.count_o), sb_f.size());
        bus_f.rd_en_i = 1'b1;
        @(posedge clk); #1;
        void'(sb_f.pop_front());
        check_val("fwft pop rdata", 32'(bus_f.rdata_o), 32'(sb_f[0]));
        @(posedge clk); #1;
        bus_f.rd_en_i = 1'b0;
        void'(sb_f.pop_front());
        check_val("fwft drained empty", 32'(bus_f.empty_o), 32'(sb_f.size() == 0));
        check_val("fwft drained rd_err", 32'(bus_f.rd_error_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
